// File: rtl/lsu_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_arbiter
//
// Shares the single load-store unit port between two requesters:
//   port A - pipeline MEM stage (fixed priority)
//   port B - DMA / boot-loader master (starvation guard, optional locked burst)
// The winning port is muxed onto the LSU request bus combinationally. Load data
// from the LSU is registered at the end of the grant cycle and returned to the
// winning port one cycle later as a single-cycle rvalid pulse.
//
// Handshake: a requester raises req and holds req plus all of its request fields
// stable until it sees gnt high in the same cycle. The access is taken in that
// grant cycle; a store completes there, a load returns {rvalid,rdata} in the
// following cycle. gnt and stall are combinational.
//
// Optional build macro:
//   LSU_ARB_PERF_EN - adds saturating performance counters o_perf_a_gnt,
//                     o_perf_b_gnt and o_perf_conflict (CNT_W bits each).
//
// Ports:
//   i_clk, i_reset          clock (rising edge), async active-low reset
//   i_a_*                   port A request: req, wren, funct3, addr, wdata
//   o_a_gnt/o_a_stall       port A grant and stall (req & ~gnt)
//   o_a_rvalid/o_a_rdata    port A load return
//   i_b_*                   port B request fields, plus i_b_lock (burst lock)
//   o_b_gnt                 port B grant
//   o_b_rvalid/o_b_rdata    port B load return
//   o_lsu_addr/o_lsu_wren/o_funct3/o_st_data   LSU request bus
//   i_ld_data               LSU load data, valid in the grant cycle
//   o_dbg_state             arbiter FSM state (0 = ARB, 1 = B_LOCK)
// -----------------------------------------------------------------------------
module lsu_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16,
    parameter int CNT_W        = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_a_req,
    input  logic        i_a_wren,
    input  logic [2:0]  i_a_funct3,
    input  logic [31:0] i_a_addr,
    input  logic [31:0] i_a_wdata,
    output logic        o_a_gnt,
    output logic        o_a_stall,
    output logic        o_a_rvalid,
    output logic [31:0] o_a_rdata,
    input  logic        i_b_req,
    input  logic        i_b_wren,
    input  logic [2:0]  i_b_funct3,
    input  logic [31:0] i_b_addr,
    input  logic [31:0] i_b_wdata,
    input  logic        i_b_lock,
    output logic        o_b_gnt,
    output logic        o_b_rvalid,
    output logic [31:0] o_b_rdata,
    output logic [31:0] o_lsu_addr,
    output logic        o_lsu_wren,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_st_data,
    input  logic [31:0] i_ld_data,
    output logic [1:0]  o_dbg_state
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] o_perf_a_gnt,
    output logic [CNT_W-1:0] o_perf_b_gnt,
    output logic [CNT_W-1:0] o_perf_conflict
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    // With LOCK_MAX==1 the entry grant already uses the whole burst budget,
    // so the FSM never enters B_LOCK.
    localparam bit LOCK_CAN_HOLD = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        B_LOCK = 2'd1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          a_gnt, b_gnt;
    logic          lock_hold;

    logic          a_rvalid_q, b_rvalid_q;
    logic [31:0]   a_rdata_q, b_rdata_q;

    // ------------------------------------------------------------------
    // Next-state and grant logic
    // ------------------------------------------------------------------
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        lock_hold = 1'b0;
        state_d   = state_q;
        starve_d  = starve_q;
        lock_d    = lock_q;

        // Grants are suppressed while reset is asserted so requesters that
        // are already driving req see nothing until release.
        if (i_reset) begin
            lock_hold = (state_q == B_LOCK) && i_b_req && i_b_lock;
            if (lock_hold) begin
                b_gnt    = 1'b1;
                starve_d = '0;
                lock_d   = lock_q + LW'(1);
                // This grant is the last one of the burst; A wins the next
                // conflict because starve_cnt is zero.
                if (lock_q == LW'(LOCK_MAX - 1)) begin
                    state_d = ARB;
                end
            end else begin
                // ARB, or the exit cycle of a burst (arbitrated as ARB).
                state_d = ARB;
                if (i_a_req && i_b_req) begin
                    if (starve_q == SW'(STARVE_LIMIT)) begin
                        b_gnt = 1'b1;
                    end else begin
                        a_gnt = 1'b1;
                    end
                end else if (i_a_req) begin
                    a_gnt = 1'b1;
                end else if (i_b_req) begin
                    b_gnt = 1'b1;
                end

                // B requesting but not granted can only mean A won a conflict.
                if (b_gnt || !i_b_req) begin
                    starve_d = '0;
                end else if (starve_q != SW'(STARVE_LIMIT)) begin
                    starve_d = starve_q + SW'(1);
                end

                if (b_gnt && i_b_lock) begin
                    lock_d = LW'(1);
                    if (LOCK_CAN_HOLD) begin
                        state_d = B_LOCK;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ARB;
            starve_q <= '0;
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
        end
    end

    // ------------------------------------------------------------------
    // LSU request bus: plain mux of the granted port, zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        o_lsu_addr = '0;
        o_lsu_wren = 1'b0;
        o_funct3   = '0;
        o_st_data  = '0;
        if (a_gnt) begin
            o_lsu_addr = i_a_addr;
            o_lsu_wren = i_a_wren;
            o_funct3   = i_a_funct3;
            o_st_data  = i_a_wdata;
        end else if (b_gnt) begin
            o_lsu_addr = i_b_addr;
            o_lsu_wren = i_b_wren;
            o_funct3   = i_b_funct3;
            o_st_data  = i_b_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Load return: capture LSU data at the end of the grant cycle
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_gnt && !i_a_wren;
            b_rvalid_q <= b_gnt && !i_b_wren;
            if (a_gnt && !i_a_wren) begin
                a_rdata_q <= i_ld_data;
            end
            if (b_gnt && !i_b_wren) begin
                b_rdata_q <= i_ld_data;
            end
        end
    end

`ifdef LSU_ARB_PERF_EN
    logic [CNT_W-1:0] perf_a_q, perf_b_q, perf_c_q;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            perf_a_q <= '0;
            perf_b_q <= '0;
            perf_c_q <= '0;
        end else begin
            if (a_gnt && (perf_a_q != '1)) perf_a_q <= perf_a_q + CNT_W'(1);
            if (b_gnt && (perf_b_q != '1)) perf_b_q <= perf_b_q + CNT_W'(1);
            if (i_a_req && i_b_req && (perf_c_q != '1)) perf_c_q <= perf_c_q + CNT_W'(1);
        end
    end

    assign o_perf_a_gnt    = perf_a_q;
    assign o_perf_b_gnt    = perf_b_q;
    assign o_perf_conflict = perf_c_q;
`endif

    assign o_a_gnt     = a_gnt;
    assign o_b_gnt     = b_gnt;
    assign o_a_stall   = i_a_req && !a_gnt;
    assign o_a_rvalid  = a_rvalid_q;
    assign o_b_rvalid  = b_rvalid_q;
    assign o_a_rdata   = a_rdata_q;
    assign o_b_rdata   = b_rdata_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_arbiter
//
// Bench for lsu_arbiter with STARVE_LIMIT=4, LOCK_MAX=16. A rule-level model
// (grant decision from request flags, starvation and burst counters, load
// return as "what was granted last cycle") is compared against the DUT on
// every falling edge. Directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_lsu_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 16;
    localparam int CNT_W        = 16;

    // ---------------- clock / reset ----------------
    logic        i_clk = 1'b0;
    logic        i_reset;
    always #5 i_clk = ~i_clk;

    logic        i_a_req, i_a_wren, i_b_req, i_b_wren, i_b_lock;
    logic [2:0]  i_a_funct3, i_b_funct3;
    logic [31:0] i_a_addr, i_a_wdata, i_b_addr, i_b_wdata;
    logic        o_a_gnt, o_a_stall, o_a_rvalid, o_b_gnt, o_b_rvalid, o_lsu_wren;
    logic [31:0] o_a_rdata, o_b_rdata, o_lsu_addr, o_st_data, i_ld_data;
    logic [2:0]  o_funct3;
    logic [1:0]  o_dbg_state;
`ifdef LSU_ARB_PERF_EN
    logic [CNT_W-1:0] o_perf_a_gnt, o_perf_b_gnt, o_perf_conflict;
`endif

    lsu_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .LOCK_MAX    (LOCK_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_a_req    (i_a_req),
        .i_a_wren   (i_a_wren),
        .i_a_funct3 (i_a_funct3),
        .i_a_addr   (i_a_addr),
        .i_a_wdata  (i_a_wdata),
        .o_a_gnt    (o_a_gnt),
        .o_a_stall  (o_a_stall),
        .o_a_rvalid (o_a_rvalid),
        .o_a_rdata  (o_a_rdata),
        .i_b_req    (i_b_req),
        .i_b_wren   (i_b_wren),
        .i_b_funct3 (i_b_funct3),
        .i_b_addr   (i_b_addr),
        .i_b_wdata  (i_b_wdata),
        .i_b_lock   (i_b_lock),
        .o_b_gnt    (o_b_gnt),
        .o_b_rvalid (o_b_rvalid),
        .o_b_rdata  (o_b_rdata),
        .o_lsu_addr (o_lsu_addr),
        .o_lsu_wren (o_lsu_wren),
        .o_funct3   (o_funct3),
        .o_st_data  (o_st_data),
        .i_ld_data  (i_ld_data),
        .o_dbg_state(o_dbg_state)
`ifdef LSU_ARB_PERF_EN
        ,
        .o_perf_a_gnt   (o_perf_a_gnt),
        .o_perf_b_gnt   (o_perf_b_gnt),
        .o_perf_conflict(o_perf_conflict)
`endif
    );

    // ---------------- LSU memory stand-in ----------------
    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign i_ld_data = mem_rd(o_lsu_addr);

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_locked;    // 1 while a locked burst owns the port
    int          m_lock_n;    // grants issued in the current burst
    int          m_starve;    // conflicts B has lost in a row
    logic        exp_a_rv, exp_b_rv;
    logic [31:0] exp_a_rd, exp_b_rd;

    // 0 = nobody, 1 = A, 2 = B
    function automatic int model_grant();
        if (!i_reset) return 0;
        if (m_locked != 0 && i_b_req && i_b_lock) return 2;
        if (i_a_req && i_b_req) return (m_starve == STARVE_LIMIT) ? 2 : 1;
        if (i_a_req) return 1;
        if (i_b_req) return 2;
        return 0;
    endfunction

    always @(posedge i_clk or negedge i_reset) begin
        int g;
        if (!i_reset) begin
            m_locked = 0;
            m_lock_n = 0;
            m_starve = 0;
            exp_a_rv = 1'b0;
            exp_b_rv = 1'b0;
            exp_a_rd = '0;
            exp_b_rd = '0;
        end else begin
            g = model_grant();
            exp_a_rv = (g == 1) && !i_a_wren;
            exp_b_rv = (g == 2) && !i_b_wren;
            if (exp_a_rv) exp_a_rd = mem_rd(i_a_addr);
            if (exp_b_rv) exp_b_rd = mem_rd(i_b_addr);
            if (m_locked != 0 && i_b_req && i_b_lock) begin
                m_lock_n = m_lock_n + 1;
                m_starve = 0;
                if (m_lock_n == LOCK_MAX) m_locked = 0;
            end else begin
                m_locked = 0;
                if (g == 2 || !i_b_req) m_starve = 0;
                else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
                if (g == 2 && i_b_lock) begin
                    m_lock_n = 1;
                    m_locked = (LOCK_MAX > 1) ? 1 : 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge i_clk) begin
        int          g;
        logic [31:0] e_addr, e_wd;
        logic [2:0]  e_f3;
        logic        e_wren;
        g      = model_grant();
        e_addr = '0;
        e_wd   = '0;
        e_f3   = '0;
        e_wren = 1'b0;
        if (g == 1) begin
            e_addr = i_a_addr; e_wd = i_a_wdata; e_f3 = i_a_funct3; e_wren = i_a_wren;
        end else if (g == 2) begin
            e_addr = i_b_addr; e_wd = i_b_wdata; e_f3 = i_b_funct3; e_wren = i_b_wren;
        end
        chk("a_gnt",    32'(o_a_gnt),     32'(g == 1));
        chk("b_gnt",    32'(o_b_gnt),     32'(g == 2));
        chk("a_stall",  32'(o_a_stall),   32'(i_a_req && g != 1));
        chk("lsu_wren", 32'(o_lsu_wren),  32'(e_wren));
        chk("lsu_addr", o_lsu_addr,       e_addr);
        chk("funct3",   32'(o_funct3),    32'(e_f3));
        chk("st_data",  o_st_data,        e_wd);
        chk("a_rvalid", 32'(o_a_rvalid),  32'(exp_a_rv));
        chk("b_rvalid", 32'(o_b_rvalid),  32'(exp_b_rv));
        chk("state",    32'(o_dbg_state), 32'(m_locked));
        if (exp_a_rv) chk("a_rdata", o_a_rdata, exp_a_rd);
        if (exp_b_rv) chk("b_rdata", o_b_rdata, exp_b_rd);
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_req = 1'b0; i_a_wren = 1'b0; i_a_funct3 = 3'b0; i_a_addr = '0; i_a_wdata = '0;
        i_b_req = 1'b0; i_b_wren = 1'b0; i_b_funct3 = 3'b0; i_b_addr = '0; i_b_wdata = '0;
        i_b_lock = 1'b0;
    endtask

    task automatic set_a(input logic wren, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        i_a_req = 1'b1; i_a_wren = wren; i_a_funct3 = f3; i_a_addr = addr; i_a_wdata = wd;
    endtask

    task automatic set_b(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic lock);
        i_b_req = 1'b1; i_b_wren = wren; i_b_funct3 = f3; i_b_addr = addr; i_b_wdata = wd;
        i_b_lock = lock;
    endtask

    function automatic logic [2:0] rand_f3();
        logic [2:0] tbl [5];
        tbl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        return tbl[$urandom_range(0, 4)];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0]  a_pat10, b_pat10;
        logic [17:0] a_pat18, b_pat18;
        logic        a_g, b_g;
`ifdef LSU_ARB_PERF_EN
        logic [CNT_W-1:0] pa0, pb0, pc0;
`endif

        // Reset with both requesters already asking.
        idle_inputs();
        i_reset = 1'b0;
        set_a(1'b0, 3'b010, 32'h10, 32'h0);
        set_b(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        repeat (2) @(negedge i_clk);
        chk("rst_a_gnt",    32'(o_a_gnt),     32'd0);
        chk("rst_b_gnt",    32'(o_b_gnt),     32'd0);
        chk("rst_a_rvalid", 32'(o_a_rvalid),  32'd0);
        chk("rst_b_rvalid", 32'(o_b_rvalid),  32'd0);
        chk("rst_a_rdata",  o_a_rdata,        32'd0);
        chk("rst_b_rdata",  o_b_rdata,        32'd0);
        chk("rst_state",    32'(o_dbg_state), 32'd0);

        // A load from 0x10 right after release.
        next_cycle();
        i_reset = 1'b1;
        idle_inputs();
        set_a(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge i_clk);
        chk("ld_a_gnt", 32'(o_a_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge i_clk);
        chk("ld_a_rvalid", 32'(o_a_rvalid), 32'd1);
        chk("ld_a_rdata",  o_a_rdata,       32'hDEAD_BEEF);
        next_cycle();

        // Continuous conflict: A,A,A,A,B repeating.
`ifdef LSU_ARB_PERF_EN
        pa0 = o_perf_a_gnt; pb0 = o_perf_b_gnt; pc0 = o_perf_conflict;
`endif
        set_a(1'b0, 3'b010, 32'h100, 32'h0);
        set_b(1'b1, 3'b010, 32'h200, 32'hCAFE_0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            a_pat10[i] = o_a_gnt;
            b_pat10[i] = o_b_gnt;
            next_cycle();
        end
        chk("conflict_a_pattern", 32'(a_pat10), 32'h1EF);
        chk("conflict_b_pattern", 32'(b_pat10), 32'h210);
`ifdef LSU_ARB_PERF_EN
        chk("perf_conflict", 32'(o_perf_conflict - pc0), 32'd10);
        chk("perf_a_gnt",    32'(o_perf_a_gnt - pa0),    32'd8);
        chk("perf_b_gnt",    32'(o_perf_b_gnt - pb0),    32'd2);
`endif
        idle_inputs();
        next_cycle();

        // Locked burst: B alone locks, A arrives one cycle later and waits.
        set_b(1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            a_g = o_a_gnt;
            if (i < 18) begin
                a_pat18[i] = o_a_gnt;
                b_pat18[i] = o_b_gnt;
            end
            next_cycle();
            if (i == 0) set_a(1'b0, 3'b010, 32'h400, 32'h0);
            else if (a_g) i_a_req = 1'b0;
        end
        chk("lock_b_pattern", 32'(b_pat18), 32'h2FFFF);
        chk("lock_a_pattern", 32'(a_pat18), 32'h10000);
        idle_inputs();
        next_cycle();

        // A store byte routes straight through in its grant cycle only.
        set_a(1'b1, 3'b000, 32'h1000_0000, 32'h55);
        @(negedge i_clk);
        chk("st_gnt",  32'(o_a_gnt),    32'd1);
        chk("st_wren", 32'(o_lsu_wren), 32'd1);
        chk("st_addr", o_lsu_addr,      32'h1000_0000);
        chk("st_f3",   32'(o_funct3),   32'd0);
        chk("st_data", o_st_data,       32'h55);
        next_cycle();
        idle_inputs();
        @(negedge i_clk);
        chk("st_after_wren", 32'(o_lsu_wren), 32'd0);
        chk("st_after_addr", o_lsu_addr,      32'd0);
        next_cycle();

        // Reset in the fifth cycle of a locked B load burst.
        set_b(1'b0, 3'b010, 32'h500, 32'h0, 1'b1);
        repeat (4) begin
            @(negedge i_clk);
            next_cycle();
        end
        #2 i_reset = 1'b0;
        @(negedge i_clk);
        chk("mrst_state",    32'(o_dbg_state), 32'd0);
        chk("mrst_b_rvalid", 32'(o_b_rvalid),  32'd0);
        chk("mrst_b_gnt",    32'(o_b_gnt),     32'd0);
        next_cycle();
        @(negedge i_clk);
        chk("mrst_b_rvalid_next", 32'(o_b_rvalid), 32'd0);
        next_cycle();
        i_reset = 1'b1;
        set_a(1'b0, 3'b010, 32'h600, 32'h0);
        @(negedge i_clk);
        chk("mrst_a_first_gnt", 32'(o_a_gnt), 32'd1);
        chk("mrst_b_held_off",  32'(o_b_gnt), 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Random traffic; each side holds its request until granted.
        a_g = 1'b0;
        b_g = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_a_req || a_g) begin
                if ($urandom_range(0, 99) < 55)
                    set_a(1'($urandom_range(0, 1)), rand_f3(),
                          ($urandom_range(0, 3) == 0) ? 32'h10 : ($urandom & 32'hFFFF_FFFC), $urandom);
                else
                    i_a_req = 1'b0;
            end
            if (!i_b_req || b_g) begin
                if ($urandom_range(0, 99) < 70)
                    set_b(1'($urandom_range(0, 1)), rand_f3(), $urandom & 32'hFFFF_FFFC,
                          $urandom, 1'($urandom_range(0, 9) < 8));
                else begin
                    i_b_req  = 1'b0;
                    i_b_lock = 1'($urandom_range(0, 1));
                end
            end
            @(negedge i_clk);
            a_g = o_a_gnt;
            b_g = o_b_gnt;
            next_cycle();
        end

        idle_inputs();
        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
